// File: rtl/iic_bus_arbiter_pkg.sv
// Shared types and constants for the two-master I2C pad arbiter.
// Master 0 is the AXI IIC core and master 1 is the GPIO bit-bang pair.
package iic_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        DRAIN
    } state_t;

    localparam int M_IIC  = 0;
    localparam int M_GPIO = 1;

    localparam int DEFAULT_IDLE_CYCLES = 1000;

endpackage

// File: rtl/iic_bus_arbiter_monitor.sv
// Bus monitor: synchronises the pads, detects START/STOP and keeps bus_busy.
// An idle timeout clears bus_busy after a transfer is abandoned without a STOP.
module iic_bus_monitor
    import iic_arb_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int IDLE_CYCLES = DEFAULT_IDLE_CYCLES,
    parameter int CNT_W       = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic pad_scl_i,
    input  logic pad_sda_i,
    output logic scl_s,
    output logic sda_s,
    output logic bus_busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   sda_prev;
    logic [CNT_W-1:0]       idle_cnt;
    logic                   start_det;
    logic                   stop_det;

    // Synchronisers reset to 1 so a released bus looks idle straight out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], pad_scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], pad_sda_i};
            sda_prev <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign start_det = scl_s & sda_prev & ~sda_s;
    assign stop_det  = scl_s & ~sda_prev & sda_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
            bus_busy <= 1'b0;
        end else begin
            if (start_det || !scl_s || !sda_s) begin
                idle_cnt <= '0;
            end else if (idle_cnt != CNT_MAX) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (start_det) begin
                bus_busy <= 1'b1;
            end else if (stop_det || idle_cnt == CNT_MAX) begin
                bus_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/iic_bus_arbiter.sv
// Two-master I2C pad arbiter: grants the SCL/SDA pads to one master at a time
// and changes owner only while the bus is idle.
module iic_bus_arbiter
    import iic_arb_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int IDLE_CYCLES = DEFAULT_IDLE_CYCLES,
    parameter int CNT_W       = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    input  logic [1:0] m_scl_o,
    input  logic [1:0] m_scl_t,
    input  logic [1:0] m_sda_o,
    input  logic [1:0] m_sda_t,
    output logic [1:0] m_scl_i,
    output logic [1:0] m_sda_i,
    output logic       pad_scl_o,
    output logic       pad_scl_t,
    output logic       pad_sda_o,
    output logic       pad_sda_t,
    input  logic       pad_scl_i,
    input  logic       pad_sda_i,
    output logic       bus_busy_o,
    output logic       collision_o
);

    state_t     state_q, state_d;
    logic       own_q, own_d;
    logic       rr_q, rr_d;
    logic [1:0] gnt_d;
    logic       collision_d;
    logic       scl_s, sda_s;

    iic_bus_monitor #(
        .SYNC_STAGES (SYNC_STAGES),
        .IDLE_CYCLES (IDLE_CYCLES),
        .CNT_W       (CNT_W)
    ) u_monitor (
        .clk       (clk),
        .rst       (rst),
        .pad_scl_i (pad_scl_i),
        .pad_sda_i (pad_sda_i),
        .scl_s     (scl_s),
        .sda_s     (sda_s),
        .bus_busy  (bus_busy_o)
    );

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (|req_i && !bus_busy_o && scl_s && sda_s) begin
                    state_d = OWN;
                    own_d   = (req_i == 2'b11) ? rr_q : req_i[1];
                end
            end
            OWN: begin
                if (!req_i[own_q]) begin
                    if (bus_busy_o) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = IDLE;
                        rr_d    = ~own_q;
                    end
                end
            end
            DRAIN: begin
                // Owner keeps the pads until its STOP (or the timeout) lands
                if (req_i[own_q]) begin
                    state_d = OWN;
                end else if (!bus_busy_o) begin
                    state_d = IDLE;
                    rr_d    = ~own_q;
                end
            end
            default: state_d = IDLE;
        endcase
        gnt_d = (state_d == IDLE) ? 2'b00 : (own_d ? 2'b10 : 2'b01);
    end

    assign collision_d = |(~gnt_o & ((~m_sda_t & ~m_sda_o) | (~m_scl_t & ~m_scl_o)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            own_q       <= 1'b0;
            rr_q        <= 1'b0;
            gnt_o       <= 2'b00;
            collision_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            own_q       <= own_d;
            rr_q        <= rr_d;
            gnt_o       <= gnt_d;
            collision_o <= collision_d;
        end
    end

    // Pads follow the registered grant, so reset releases them without a clock
    always_comb begin
        pad_scl_o = 1'b1;
        pad_scl_t = 1'b1;
        pad_sda_o = 1'b1;
        pad_sda_t = 1'b1;
        if (gnt_o[M_IIC]) begin
            pad_scl_o = m_scl_o[M_IIC];
            pad_scl_t = m_scl_t[M_IIC];
            pad_sda_o = m_sda_o[M_IIC];
            pad_sda_t = m_sda_t[M_IIC];
        end else if (gnt_o[M_GPIO]) begin
            pad_scl_o = m_scl_o[M_GPIO];
            pad_scl_t = m_scl_t[M_GPIO];
            pad_sda_o = m_sda_o[M_GPIO];
            pad_sda_t = m_sda_t[M_GPIO];
        end
    end

    assign m_scl_i = {2{pad_scl_i}};
    assign m_sda_i = {2{pad_sda_i}};

endmodule
